// File: rtl/aes_shift_row_ctrl_if.sv
// Byte stream and row-memory bundle for the ShiftRows sequencer.
// The slave side is the controller; the master side feeds it and owns the memory.
interface aes_shift_row_ctrl_if;
   logic       decrypt;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       mem_wr_en;
   logic [2:0] mem_wr_addr;
   logic [7:0] mem_wr_data;
   logic [2:0] mem_rd_addr;
   logic [7:0] mem_rd_data;

   modport master (
      output decrypt, in_valid, in_data, out_ready, mem_rd_data,
      input  in_ready, out_valid, out_data, out_last,
      input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
   );

   modport slave (
      input  decrypt, in_valid, in_data, out_ready, mem_rd_data,
      output in_ready, out_valid, out_data, out_last,
      output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
   );
endinterface

// File: rtl/aes_shift_row_ctrl.sv
// Byte-serial ShiftRows/InvShiftRows sequencer over two 4-byte ping-pong
// row banks; rows stream in row-major and leave rotated by their row index.
module aes_shift_row_ctrl (
   input  logic                 clk,
   input  logic                 rst_n,
   aes_shift_row_ctrl_if.slave  bus
);
   logic            wbank_q, wbank_d;
   logic [1:0]      wcol_q, wcol_d;
   logic [1:0]      wrow_q, wrow_d;
   logic            rbank_q, rbank_d;
   logic [1:0]      rcol_q, rcol_d;
   logic [1:0]      full_q, full_d;
   logic [1:0]      bank_mode_q, bank_mode_d;
   logic [1:0][1:0] bank_row_q, bank_row_d;
   logic            blk_mode_q, blk_mode_d;

   logic       in_fire;
   logic       out_fire;
   logic       blk_start;
   logic       cur_mode;
   logic [1:0] shift;
   logic [1:0] rd_col;

   // Write enable is masked while reset is held so nothing lands mid-reset.
   assign in_fire   = bus.in_valid & ~full_q[wbank_q] & rst_n;
   assign out_fire  = full_q[rbank_q] & bus.out_ready;
   assign blk_start = (wrow_q == 2'd0) & (wcol_q == 2'd0);
   assign cur_mode  = blk_start ? bus.decrypt : blk_mode_q;

   // Inverse rotation is a negated shift in 2-bit wrap arithmetic.
   assign shift  = bank_mode_q[rbank_q] ? 2'd0 - bank_row_q[rbank_q]
                                        : bank_row_q[rbank_q];
   assign rd_col = rcol_q + shift;

   assign bus.in_ready    = ~full_q[wbank_q];
   assign bus.mem_wr_en   = in_fire;
   assign bus.mem_wr_addr = {wbank_q, wcol_q};
   assign bus.mem_wr_data = bus.in_data;
   assign bus.mem_rd_addr = {rbank_q, rd_col};
   assign bus.out_valid   = full_q[rbank_q];
   assign bus.out_data    = bus.mem_rd_data;
   assign bus.out_last    = full_q[rbank_q]
                          & (bank_row_q[rbank_q] == 2'd3)
                          & (rcol_q == 2'd3);

   always_comb begin
      wbank_d     = wbank_q;
      wcol_d      = wcol_q;
      wrow_d      = wrow_q;
      rbank_d     = rbank_q;
      rcol_d      = rcol_q;
      full_d      = full_q;
      bank_mode_d = bank_mode_q;
      bank_row_d  = bank_row_q;
      blk_mode_d  = blk_mode_q;
      if (in_fire) begin
         wcol_d = wcol_q + 2'd1;
         if (blk_start) blk_mode_d = bus.decrypt;
         if (wcol_q == 2'd3) begin
            full_d[wbank_q]      = 1'b1;
            bank_row_d[wbank_q]  = wrow_q;
            bank_mode_d[wbank_q] = cur_mode;
            wbank_d              = ~wbank_q;
            wrow_d               = wrow_q + 2'd1;
         end
      end
      // Read and write banks never coincide, so both updates can apply.
      if (out_fire) begin
         rcol_d = rcol_q + 2'd1;
         if (rcol_q == 2'd3) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbank_q     <= 1'b0;
         wcol_q      <= 2'd0;
         wrow_q      <= 2'd0;
         rbank_q     <= 1'b0;
         rcol_q      <= 2'd0;
         full_q      <= 2'b00;
         bank_mode_q <= 2'b00;
         bank_row_q  <= '0;
         blk_mode_q  <= 1'b0;
      end else begin
         wbank_q     <= wbank_d;
         wcol_q      <= wcol_d;
         wrow_q      <= wrow_d;
         rbank_q     <= rbank_d;
         rcol_q      <= rcol_d;
         full_q      <= full_d;
         bank_mode_q <= bank_mode_d;
         bank_row_q  <= bank_row_d;
         blk_mode_q  <= blk_mode_d;
      end
   end
endmodule

// File: tb/tb_aes_shift_row_ctrl.sv
// Bench for aes_shift_row_ctrl: fixed vectors, corner sequences and a
// randomly throttled run scored against a row-rotation reference model.
module tb_aes_shift_row_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   aes_shift_row_ctrl_if bus ();

   aes_shift_row_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] mem [8];
   always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
   assign bus.mem_rd_data = mem[bus.mem_rd_addr];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int outs = 0;
   int lasts = 0;

   logic [8:0] exp_q [$];
   logic [7:0] m_rows [4][4];
   int         m_cnt = 0;
   bit         m_mode = 1'b0;

   bit         stalled = 1'b0;
   logic [7:0] st_data;
   logic       st_last;

   typedef struct {
      bit         dec;
      logic [7:0] din [16];
      logic [7:0] dout [16];
   } vec_t;
   vec_t tbl [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: a completed row r yields in[r][(k + s) mod 4], s = r or -r.
   function automatic void model_in(input logic [7:0] d, input bit dec);
      int r, c, sh;
      r = m_cnt / 4;
      c = m_cnt % 4;
      if (m_cnt == 0) m_mode = dec;
      m_rows[r][c] = d;
      if (c == 3) begin
         sh = m_mode ? (4 - r) % 4 : r;
         for (int k = 0; k < 4; k++)
            exp_q.push_back({(r == 3 && k == 3), m_rows[r][(k + sh) % 4]});
      end
      m_cnt = (m_cnt + 1) % 16;
   endfunction

   task automatic tick(input bit v, input logic [7:0] d, input bit dec, input bit rdy,
                       output bit fi, output bit fo);
      int held;
      logic [8:0] e;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.decrypt   = dec;
      bus.out_ready = rdy;
      #1;
      cyc++;
      held = (exp_q.size() + 3) / 4;
      chk("in_ready", bus.in_ready, held < 2);
      chk("out_valid", bus.out_valid, held > 0);
      if (stalled) begin
         chk("stall_data", bus.out_data, st_data);
         chk("stall_last", bus.out_last, st_last);
      end
      fi = v && bus.in_ready;
      fo = bus.out_valid && rdy;
      if (fo) begin
         outs++;
         if (bus.out_last) lasts++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got byte %0h expected none", bus.out_data);
         end else begin
            checks--;
            e = exp_q.pop_front();
            chk("out_data", bus.out_data, e[7:0]);
            chk("out_last", bus.out_last, e[8]);
         end
      end
      stalled = bus.out_valid && !rdy;
      st_data = bus.out_data;
      st_last = bus.out_last;
      if (fi) model_in(d, dec);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, bus.in_ready, 1);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_out_last"}, bus.out_last, 0);
      chk({tag, "_mem_wr_en"}, bus.mem_wr_en, 0);
      chk({tag, "_mem_rd_addr"}, bus.mem_rd_addr, 0);
   endtask

   task automatic clear_model();
      exp_q.delete();
      m_cnt = 0;
      stalled = 1'b0;
   endtask

   initial begin
      bit fi, fo;
      int acc, n, i, k, first, lastc, cnt, bytes_in;
      bit cur_v, dec;
      logic [7:0] cur_d;

      tbl[0].dec  = 1'b0;
      tbl[0].dout = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07, 8'h04,
                      8'h0A, 8'h0B, 8'h08, 8'h09, 8'h0F, 8'h0C, 8'h0D, 8'h0E};
      tbl[1].dec  = 1'b1;
      tbl[1].dout = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h04, 8'h05, 8'h06,
                      8'h0A, 8'h0B, 8'h08, 8'h09, 8'h0D, 8'h0E, 8'h0F, 8'h0C};
      tbl[2].dec  = 1'b1;
      tbl[2].dout = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF7, 8'hF4, 8'hF5, 8'hF6,
                      8'hFA, 8'hFB, 8'hF8, 8'hF9, 8'hFD, 8'hFE, 8'hFF, 8'hFC};
      for (int j = 0; j < 16; j++) begin
         tbl[0].din[j] = 8'(j);
         tbl[1].din[j] = 8'(j);
         tbl[2].din[j] = 8'(8'hF0 + j);
      end

      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h00;
      bus.decrypt   = 1'b0;
      bus.out_ready = 1'b0;
      #3;
      check_reset_outputs("por");
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;

      for (int t = 0; t < 3; t++) begin
         i = 0; k = 0; n = 0;
         while (k < 16 && n < 80) begin
            tick(i < 16, (i < 16) ? tbl[t].din[i] : 8'h00, tbl[t].dec, 1'b1, fi, fo);
            if (fo) begin
               chk("vec_data", bus.out_data, tbl[t].dout[k]);
               chk("vec_last", bus.out_last, k == 15);
               k++;
            end
            if (fi) i++;
            n++;
         end
         chk("vec_count", k, 16);
      end

      // Abort a block part-way, with outputs pending and in_valid still high.
      for (int j = 0; j < 6; j++) tick(1'b1, 8'(8'h80 + j), 1'b0, 1'b0, fi, fo);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      clear_model();
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;

      acc = 0;
      for (int j = 0; j < 12; j++) begin
         tick(1'b1, 8'(acc), 1'b0, 1'b0, fi, fo);
         if (fi) acc++;
         if (j >= 8) chk("bp_data_hold", bus.out_data, 8'h00);
      end
      chk("bp_accepted", acc, 8);
      chk("bp_in_ready_low", bus.in_ready, 0);
      outs = 0; n = 0;
      while ((acc < 16 || exp_q.size() > 0) && n < 100) begin
         tick(acc < 16, 8'(acc), 1'b0, 1'b1, fi, fo);
         if (fi) acc++;
         n++;
      end
      chk("bp_drained", outs, 16);

      i = 0; n = 0; cnt = 0; first = -1; lastc = -1;
      while ((i < 32 || exp_q.size() > 0) && n < 100) begin
         dec = (i < 16) ? (i >= 8) : (i < 21);
         tick(i < 32, 8'(8'h40 + i), dec, 1'b1, fi, fo);
         if (fo) begin
            if (first < 0) first = cyc;
            lastc = cyc;
            cnt++;
         end
         if (fi) i++;
         n++;
      end
      chk("b2b_count", cnt, 32);
      chk("b2b_contiguous", lastc - first, 31);

      bytes_in = 0; n = 0; outs = 0; lasts = 0;
      cur_v = 1'b0; cur_d = 8'h00;
      while ((bytes_in < 16000 || exp_q.size() > 0) && n < 80000) begin
         if (!cur_v && bytes_in < 16000 && $urandom_range(3) != 0) begin
            cur_v = 1'b1;
            cur_d = 8'($urandom);
         end
         tick(cur_v, cur_d, 1'($urandom), $urandom_range(3) != 0, fi, fo);
         if (fi) begin
            cur_v = 1'b0;
            bytes_in++;
         end
         n++;
      end
      chk("rand_bytes_out", outs, 16000);
      chk("rand_last_count", lasts, 1000);
      chk("rand_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_shift_row_ctrl.md
# aes_shift_row_ctrl

Byte-serial ShiftRows/InvShiftRows sequencer for the iterative AES core. It owns the 8-entry dual-row byte memory and treats it as two 4-byte ping-pong row banks. It accepts state bytes row-major over a valid/ready stream and emits each row rotated by its row index. It sits between the SubBytes byte stage and the MixColumns column loader.

## Interface
Parameters:
- None; geometry is fixed at 4 rows x 4 bytes, 2 banks, 3-bit memory address.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- decrypt  in  1  0 = ShiftRows (rotate left), 1 = InvShiftRows (rotate right); sampled per block
- in_valid  in  1  input byte valid
- in_ready  out  1  controller can accept input byte
- in_data  in  8  input state byte, row-major (row r, byte c)
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts output byte
- out_data  out  8  shifted output byte (= mem_rd_data, combinational)
- out_last  out  1  high with the final byte of a block (row 3, byte 3)
- mem_wr_en  out  1  memory write enable
- mem_wr_addr  out  3  {bank, byte}
- mem_wr_data  out  8  = in_data
- mem_rd_addr  out  3  {bank, rotated byte}
- mem_rd_data  in  8  asynchronous read data from memory

## Operation
- Write side: counters wbank (1b), wcol (2b), wrow (2b). Input fire = in_valid && in_ready.
- in_ready = !full[wbank]. mem_wr_en = input fire, combinationally. mem_wr_addr = {wbank, wcol}.
- On fire, wcol increments. When wcol == 3, the following happen: full[wbank] is set, bank_row[wbank] = wrow, bank_mode[wbank] = current block mode, wbank toggles, wrow increments (wraps 3 -> 0).
- Block mode: when row 0 byte 0 is accepted, decrypt is latched into blk_mode. For the first row, that same-cycle decrypt value is used. decrypt changes mid-block have no effect.
- Read side: counters rbank (1b), rcol (2b). out_valid = full[rbank].
- Shift amount s = bank_row[rbank] for encrypt, (4 - bank_row[rbank]) mod 4 for decrypt.
- mem_rd_addr = {rbank, (rcol + s) mod 4}, 2-bit wrap arithmetic.
- Output fire = out_valid && out_ready; on fire, rcol increments.
- When rcol == 3, full[rbank] is cleared and rbank toggles.
- out_last = out_valid && bank_row[rbank] == 3 && rcol == 3.
- Simultaneous row completion on write bank and read bank in the same cycle is legal: both updates apply. Banks never alias because writes are gated by full.
- Both banks full: in_ready = 0 until the read side drains one row.
- Back-to-back blocks: wrow wraps to 0 and the next block streams in without a bubble.

## Timing
- Reset (async, rst_n low) clears all counters, full[1:0], bank_row, bank_mode and blk_mode to 0. Resulting outputs: in_ready = 1, out_valid = 0, out_last = 0, mem_wr_en = 0, mem_rd_addr = 0.
- Reset mid-block discards all partial and buffered rows. There is no memory clear; stale data is unreachable.
- Latency: the first byte of row r is valid the cycle after its 4th byte is accepted.
- Throughput: 1 byte/cycle sustained with out_ready held high. 16 bytes per block, no idle cycles.
- out_data follows mem_rd_addr combinationally within the same cycle. Only out_valid, out_last and mem_rd_addr are state-derived.
- out_valid, once asserted, stays high until the byte is accepted. out_data and out_last stay stable while stalled.

## Test plan
- Reset check: drive rst_n low mid-stream. Required: in_ready = 1, out_valid = 0 and mem_wr_en = 0 immediately, asynchronously.
- Encrypt block, bytes 00..0F row-major. Required outputs: row0 00 01 02 03; row1 05 06 07 04; row2 0A 0B 08 09; row3 0F 0C 0D 0E. out_last only on 0E.
- Decrypt block, same input. Required outputs: row0 00 01 02 03; row1 07 04 05 06; row2 0A 0B 08 09; row3 0D 0E 0F 0C.
- Backpressure: hold out_ready = 0 while feeding. Required: in_ready drops after 8 bytes accepted (both banks full), and out_data stays 00 stable. Releasing out_ready drains in order with no loss.
- Back-to-back blocks: feed an encrypt block, then a decrypt block, with decrypt toggled mid-block. Required: per-block mode honoured, 32 contiguous output bytes.
- Random valid/ready throttling over 1000 blocks against a reference model. Required: zero mismatches and exactly one out_last per 16 bytes.
